// File: rtl/myalu_seq.sv
// Handshaked ALU: add/sub, logic, shifts, set-less-than, iterative multiply.
// Ports: clk, reset (async low); in_valid/in_ready, A, B, opcode in;
//        out_valid pulse, result, carryout, overflow, zero, busy out.
module myalu_seq #(
   parameter int NUMBITS = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [NUMBITS-1:0] A,
   input  logic [NUMBITS-1:0] B,
   input  logic [3:0]         opcode,
   output logic               out_valid,
   output logic [NUMBITS-1:0] result,
   output logic               carryout,
   output logic               overflow,
   output logic               zero,
   output logic               busy
);

   localparam int SW = $clog2(NUMBITS);
   localparam int DW = 2 * NUMBITS;
   localparam logic [SW-1:0] CNT_LAST = SW'(NUMBITS - 1);

   localparam logic [3:0] OP_ADDU = 4'b0000;
   localparam logic [3:0] OP_ADDS = 4'b0001;
   localparam logic [3:0] OP_SUBU = 4'b0010;
   localparam logic [3:0] OP_SUBS = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_OR   = 4'b0101;
   localparam logic [3:0] OP_XOR  = 4'b0110;
   localparam logic [3:0] OP_SHR1 = 4'b0111;
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_SRA  = 4'b1010;
   localparam logic [3:0] OP_MUL  = 4'b1011;
   localparam logic [3:0] OP_SLT  = 4'b1100;
   localparam logic [3:0] OP_SLTU = 4'b1101;

   typedef enum logic {
      IDLE,
      MUL
   } state_t;

   state_t state, state_nx;

   logic accept;
   logic ld_mul;
   logic alu_done;
   logic mul_done;

   logic [NUMBITS:0]   sum;
   logic [NUMBITS:0]   dif;
   logic [SW-1:0]      shamt;
   logic               sa;
   logic               sb;
   logic [NUMBITS-1:0] alu_res;
   logic               alu_c;
   logic               alu_o;

   logic [DW-1:0]      mcand;
   logic [DW-1:0]      acc;
   logic [DW-1:0]      acc_sum;
   logic [NUMBITS-1:0] mplr;
   logic [SW-1:0]      cnt;
   logic               mul_hi;

   assign in_ready = (state == IDLE);
   assign busy     = (state == MUL);
   assign accept   = in_valid && in_ready;

   // ---------------- single-cycle datapath ----------------
   assign sum   = {1'b0, A} + {1'b0, B};
   assign dif   = {1'b0, A} - {1'b0, B};
   assign shamt = B[SW-1:0];
   assign sa    = A[NUMBITS-1];
   assign sb    = B[NUMBITS-1];

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_o   = 1'b0;
      unique case (opcode)
         OP_ADDU: begin
            alu_res = sum[NUMBITS-1:0];
            alu_c   = sum[NUMBITS];
         end
         OP_ADDS: begin
            alu_res = sum[NUMBITS-1:0];
            alu_c   = sum[NUMBITS];
            alu_o   = (sa == sb) && (sum[NUMBITS-1] != sa);
         end
         OP_SUBU: begin
            alu_res = dif[NUMBITS-1:0];
            alu_c   = dif[NUMBITS];
         end
         OP_SUBS: begin
            alu_res = dif[NUMBITS-1:0];
            alu_c   = dif[NUMBITS];
            alu_o   = (sa != sb) && (dif[NUMBITS-1] != sa);
         end
         OP_AND:  alu_res = A & B;
         OP_OR:   alu_res = A | B;
         OP_XOR:  alu_res = A ^ B;
         OP_SHR1: alu_res = A >> 1;
         OP_SLL:  alu_res = A << shamt;
         OP_SRL:  alu_res = A >> shamt;
         OP_SRA:  alu_res = $signed(A) >>> shamt;
         OP_SLT: begin
            alu_res = {{(NUMBITS-1){1'b0}},
                       ($signed(A) < $signed(B))};
         end
         OP_SLTU: begin
            alu_res = {{(NUMBITS-1){1'b0}}, (A < B)};
         end
         // reserved codes and OP_MUL leave result at 0
         default: alu_res = '0;
      endcase
   end

   // ---------------- multiplier step ----------------
   // Final iteration's sum goes straight to the outputs,
   // so completion does not cost an extra cycle.
   assign acc_sum = acc + (mplr[0] ? mcand : '0);
   assign mul_hi  = |acc_sum[DW-1:NUMBITS];

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      ld_mul   = 1'b0;
      alu_done = 1'b0;
      mul_done = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               if (opcode == OP_MUL) begin
                  ld_mul   = 1'b1;
                  state_nx = MUL;
               end else begin
                  alu_done = 1'b1;
               end
            end
         end
         MUL: begin
            if (cnt == CNT_LAST) begin
               mul_done = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // ---------------- multiplier registers ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mcand <= '0;
         acc   <= '0;
         mplr  <= '0;
         cnt   <= '0;
      end else if (ld_mul) begin
         mcand <= {{NUMBITS{1'b0}}, A};
         acc   <= '0;
         mplr  <= B;
         cnt   <= '0;
      end else if (state == MUL) begin
         acc   <= acc_sum;
         mcand <= mcand << 1;
         mplr  <= mplr >> 1;
         cnt   <= cnt + SW'(1);
      end
   end

   // ---------------- output registers ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         result    <= '0;
         carryout  <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (alu_done) begin
            result    <= alu_res;
            carryout  <= alu_c;
            overflow  <= alu_o;
            zero      <= (alu_res == '0);
            out_valid <= 1'b1;
         end else if (mul_done) begin
            result    <= acc_sum[NUMBITS-1:0];
            carryout  <= mul_hi;
            overflow  <= mul_hi;
            zero      <= (acc_sum[NUMBITS-1:0] == '0);
            out_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_myalu_seq.sv
// Scoreboard bench for myalu_seq (NUMBITS=16).
// Stimulus pushes expectations; a monitor pops on out_valid.
module tb_myalu_seq;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] A;
   logic [15:0] B;
   logic [3:0]  opcode;
   logic        out_valid;
   logic [15:0] result;
   logic        carryout;
   logic        overflow;
   logic        zero;
   logic        busy;

   myalu_seq #(.NUMBITS(16)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .opcode(opcode),
      .out_valid(out_valid), .result(result),
      .carryout(carryout), .overflow(overflow),
      .zero(zero), .busy(busy)
   );

   typedef struct {
      string       nm;
      logic [15:0] r;
      logic        c;
      logic        o;
      logic        z;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // monitor
   always @(negedge clk) begin
      exp_t e;
      if (reset === 1'b1 && out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected out_valid at cycle %0d result %0h",
                     cyc, result);
         end else begin
            e = sb.pop_front();
            chk({e.nm, ".result"}, 32'(result), 32'(e.r));
            chk({e.nm, ".carry"}, 32'(carryout), 32'(e.c));
            chk({e.nm, ".ovf"}, 32'(overflow), 32'(e.o));
            chk({e.nm, ".zero"}, 32'(zero), 32'(e.z));
            chk({e.nm, ".cycle"}, 32'(cyc), 32'(e.due));
         end
      end
   end

   // called at a negedge; returns at the negedge after acceptance
   task automatic send(input string nm, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] r, input logic c,
                       input logic o, input logic z, input bit push);
      exp_t e;
      int   n;
      in_valid = 1'b1;
      opcode   = op;
      A        = a;
      B        = b;
      n        = 0;
      while (in_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         chk({nm, ".ready_timeout"}, 32'(in_ready), 32'd1);
      end else if (push) begin
         e.nm  = nm;
         e.r   = r;
         e.c   = c;
         e.o   = o;
         e.z   = z;
         e.due = (op == 4'b1011) ? cyc + 1 + 16 : cyc + 1;
         sb.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      reset    = 1'b0;
      in_valid = 1'b1;
      opcode   = 4'b0000;
      A        = 16'h0001;
      B        = 16'h0001;

      // reset held with in_valid high
      repeat (4) begin
         @(negedge clk);
         chk("rst.out_valid", 32'(out_valid), 32'd0);
         chk("rst.result", 32'(result), 32'd0);
         chk("rst.zero", 32'(zero), 32'd0);
         chk("rst.busy", 32'(busy), 32'd0);
      end
      reset    = 1'b1;
      in_valid = 1'b0;
      #1;
      chk("rst.in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);

      // adds
      send("adds_ovf", 4'b0001, 16'h7FFF, 16'h0001,
           16'h8000, 1'b0, 1'b1, 1'b0, 1);
      send("addu_wrap", 4'b0000, 16'hFFFF, 16'h0001,
           16'h0000, 1'b1, 1'b0, 1'b1, 1);
      idle(2);

      // sub / compare back-to-back
      send("subu", 4'b0010, 16'd3, 16'd5,
           16'hFFFE, 1'b1, 1'b0, 1'b0, 1);
      send("slt", 4'b1100, 16'd3, 16'd5,
           16'h0001, 1'b0, 1'b0, 1'b0, 1);
      send("sltu", 4'b1101, 16'd3, 16'd5,
           16'h0001, 1'b0, 1'b0, 1'b0, 1);
      send("slt_neg", 4'b1100, 16'hFFFF, 16'h0001,
           16'h0001, 1'b0, 1'b0, 1'b0, 1);
      send("sltu_big", 4'b1101, 16'hFFFF, 16'h0001,
           16'h0000, 1'b0, 1'b0, 1'b1, 1);
      send("subs_ovf", 4'b0011, 16'h8000, 16'h0001,
           16'h7FFF, 1'b0, 1'b1, 1'b0, 1);
      send("resv", 4'b1110, 16'h1234, 16'h5678,
           16'h0000, 1'b0, 1'b0, 1'b1, 1);
      send("shr1", 4'b0111, 16'h8001, 16'h0000,
           16'h4000, 1'b0, 1'b0, 1'b0, 1);
      idle(1);

      // shifts, amount taken from B[3:0]
      send("sll", 4'b1000, 16'h8001, 16'h0014,
           16'h0010, 1'b0, 1'b0, 1'b0, 1);
      send("srl", 4'b1001, 16'h8001, 16'h0014,
           16'h0800, 1'b0, 1'b0, 1'b0, 1);
      send("sra", 4'b1010, 16'h8001, 16'h0014,
           16'hF800, 1'b0, 1'b0, 1'b0, 1);

      // multiply with an AND held waiting behind it
      send("mul1", 4'b1011, 16'h0123, 16'h0045,
           16'h4E6F, 1'b0, 1'b0, 1'b0, 1);
      chk("mul1.in_ready", 32'(in_ready), 32'd0);
      chk("mul1.busy", 32'(busy), 32'd1);
      chk("mul1.hold", 32'(result), 32'hF800);
      send("and_wait", 4'b0100, 16'h0F0F, 16'h00FF,
           16'h000F, 1'b0, 1'b0, 1'b0, 1);
      chk("and.busy", 32'(busy), 32'd0);
      idle(1);

      send("mul2", 4'b1011, 16'h1000, 16'h0010,
           16'h0000, 1'b1, 1'b1, 1'b1, 1);
      idle(20);

      // reset mid-multiply
      send("mul_abort", 4'b1011, 16'h00FF, 16'h00FF,
           16'h0000, 1'b0, 1'b0, 1'b0, 0);
      idle(4);
      reset = 1'b0;
      #1;
      chk("abort.busy", 32'(busy), 32'd0);
      chk("abort.in_ready", 32'(in_ready), 32'd1);
      chk("abort.out_valid", 32'(out_valid), 32'd0);
      chk("abort.zero", 32'(zero), 32'd0);
      chk("abort.carry", 32'(carryout), 32'd0);
      chk("abort.ovf", 32'(overflow), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      send("xor", 4'b0110, 16'h00FF, 16'h0F0F,
           16'h0FF0, 1'b0, 1'b0, 1'b0, 1);
      idle(25);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
